// File: rtl/traffic_pkg.sv
// Shared definitions for the two-direction intersection controller:
// phase encodings, lamp bit positions and the fixed phase-ring order.
package traffic_pkg;

  localparam int unsigned PHASE_W = 3;

  // Lamp vector bit positions
  localparam int unsigned GREEN  = 0;
  localparam int unsigned YELLOW = 1;
  localparam int unsigned RED    = 2;

  typedef enum logic [PHASE_W-1:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALL_RED_1 = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALL_RED_2 = 3'd5,
    NIGHT     = 3'd6
  } phase_e;

  // Successor in the normal day ring; anything unexpected falls back to clearance
  function automatic phase_e next_in_ring(phase_e p);
    case (p)
      A_GREEN:   return A_YELLOW;
      A_YELLOW:  return ALL_RED_1;
      ALL_RED_1: return B_GREEN;
      B_GREEN:   return B_YELLOW;
      B_YELLOW:  return ALL_RED_2;
      ALL_RED_2: return A_GREEN;
      default:   return ALL_RED_2;
    endcase
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts enabled clk cycles and flags the last cycle
// of each second.
// Ports: clk, rst (sync, active-high), en (count enable),
//        sec_tick (high during the final cycle of each second while en=1).
module sec_prescaler #(
  parameter int unsigned pTICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sec_tick
);

  localparam int unsigned CW = $clog2(pTICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(pTICKS_PER_SEC - 1);

  logic [CW-1:0] tick_cnt;

  assign sec_tick = en && (tick_cnt == LAST);

  // Wrapping cycle counter, frozen while en=0
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= sec_tick ? '0 : tick_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-direction intersection controller (A = main road, B = side road).
// Sequences green/yellow/all-red phases, shortens A green on a pending
// side-road request, supports a flashing-yellow night mode and drives
// per-direction countdown values.
// Ports: clk, rst (sync, active-high), en (run enable), night (level),
//        ped_req (pulse/level); light_a/light_b ([0]=G [1]=Y [2]=R),
//        remain_a/remain_b (seconds until that direction's light changes),
//        ped_walk, ped_pending, sec_tick, phase.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned pTICKS_PER_SEC = 100,
  parameter int unsigned pT_GREEN_A     = 15,
  parameter int unsigned pT_GREEN_B     = 10,
  parameter int unsigned pT_YELLOW      = 3,
  parameter int unsigned pT_ALL_RED     = 1,
  parameter int unsigned pT_MIN_GREEN   = 5,
  parameter int unsigned pTIME_WIDTH    = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   night,
  input  logic                   ped_req,
  output logic [2:0]             light_a,
  output logic [2:0]             light_b,
  output logic [pTIME_WIDTH-1:0] remain_a,
  output logic [pTIME_WIDTH-1:0] remain_b,
  output logic                   ped_walk,
  output logic                   ped_pending,
  output logic                   sec_tick,
  output logic [PHASE_W-1:0]     phase
);

  localparam int unsigned TW        = pTIME_WIDTH;
  localparam int unsigned MAX_GREEN = (pT_GREEN_A > pT_GREEN_B) ? pT_GREEN_A : pT_GREEN_B;

  // Reject parameter sets whose countdown sums cannot fit the display width
  if (pTICKS_PER_SEC < 2 || pT_GREEN_A < 1 || pT_GREEN_B < 1 || pT_YELLOW < 1 ||
      pT_ALL_RED < 1 || pT_MIN_GREEN < 1 || pT_MIN_GREEN > pT_GREEN_A ||
      (pT_ALL_RED + MAX_GREEN + pT_YELLOW + pT_ALL_RED) > ((1 << TW) - 1)) begin : g_param_check
    $error("traffic_intersection_ctrl: illegal timing parameters");
  end

  localparam logic [TW-1:0] T_GA    = TW'(pT_GREEN_A);
  localparam logic [TW-1:0] T_GB    = TW'(pT_GREEN_B);
  localparam logic [TW-1:0] T_Y     = TW'(pT_YELLOW);
  localparam logic [TW-1:0] T_R     = TW'(pT_ALL_RED);
  localparam logic [TW-1:0] T_MIN   = TW'(pT_MIN_GREEN);
  localparam logic [TW-1:0] T_YR    = TW'(pT_YELLOW + pT_ALL_RED);
  localparam logic [TW-1:0] T_GB_YR = TW'(pT_GREEN_B + pT_YELLOW + pT_ALL_RED);
  localparam logic [TW-1:0] T_GA_YR = TW'(pT_GREEN_A + pT_YELLOW + pT_ALL_RED);
  localparam logic [TW-1:0] ONE     = TW'(1);

  phase_e        phase_q, phase_d;
  logic [TW-1:0] rem_q, rem_d;
  logic          flash_q, flash_d;
  logic          ped_q, ped_d;

  function automatic logic [TW-1:0] dur_of(phase_e p);
    case (p)
      A_GREEN:            return T_GA;
      B_GREEN:            return T_GB;
      A_YELLOW, B_YELLOW: return T_Y;
      default:            return T_R;
    endcase
  endfunction

  sec_prescaler #(
    .pTICKS_PER_SEC(pTICKS_PER_SEC)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sec_tick(sec_tick)
  );

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= A_GREEN;
      rem_q   <= T_GA;
      flash_q <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      flash_q <= flash_d;
      ped_q   <= ped_d;
    end
  end

  // Next phase / countdown; sec_tick already carries en, so en=0 holds everything
  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    flash_d = flash_q;
    case (phase_q)
      NIGHT: begin
        if (sec_tick) begin
          if (!night) begin
            phase_d = ALL_RED_2;
            rem_d   = T_R;
            flash_d = 1'b0;
          end else begin
            flash_d = ~flash_q;
          end
        end
      end
      A_GREEN, A_YELLOW, ALL_RED_1, B_GREEN, B_YELLOW, ALL_RED_2: begin
        if (sec_tick) begin
          if (phase_q == A_GREEN && ped_q && rem_q > T_MIN) begin
            rem_d = T_MIN;
          end else if (rem_q != ONE) begin
            rem_d = rem_q - ONE;
          end else if ((phase_q == ALL_RED_1 || phase_q == ALL_RED_2) && night) begin
            phase_d = NIGHT;
            rem_d   = T_R;
          end else begin
            phase_d = next_in_ring(phase_q);
            rem_d   = dur_of(next_in_ring(phase_q));
          end
        end
      end
      default: begin
        phase_d = ALL_RED_2;
        rem_d   = T_R;
        flash_d = 1'b0;
      end
    endcase
  end

  // Request latch: set in any cycle, cleared as B green begins (clear wins)
  always_comb begin
    ped_d = ped_q | ped_req;
    if (phase_d == B_GREEN && phase_q != B_GREEN) begin
      ped_d = 1'b0;
    end
  end

  // Lamp decode
  always_comb begin
    light_a = 3'b000;
    light_b = 3'b000;
    case (phase_q)
      A_GREEN:  begin light_a[GREEN]  = 1'b1; light_b[RED] = 1'b1; end
      A_YELLOW: begin light_a[YELLOW] = 1'b1; light_b[RED] = 1'b1; end
      B_GREEN:  begin light_a[RED] = 1'b1; light_b[GREEN]  = 1'b1; end
      B_YELLOW: begin light_a[RED] = 1'b1; light_b[YELLOW] = 1'b1; end
      NIGHT: begin
        light_a[YELLOW] = flash_q;
        light_b[YELLOW] = flash_q;
      end
      default: begin light_a[RED] = 1'b1; light_b[RED] = 1'b1; end
    endcase
  end

  // Countdown values use nominal durations of the phases still ahead
  always_comb begin
    remain_a = '0;
    remain_b = '0;
    case (phase_q)
      A_GREEN:   begin remain_a = rem_q;           remain_b = rem_q + T_YR;    end
      A_YELLOW:  begin remain_a = rem_q;           remain_b = rem_q + T_R;     end
      ALL_RED_1: begin remain_a = rem_q + T_GB_YR; remain_b = rem_q;           end
      B_GREEN:   begin remain_a = rem_q + T_YR;    remain_b = rem_q;           end
      B_YELLOW:  begin remain_a = rem_q + T_R;     remain_b = rem_q;           end
      ALL_RED_2: begin remain_a = rem_q;           remain_b = rem_q + T_GA_YR; end
      default:   begin remain_a = '0;              remain_b = '0;              end
    endcase
  end

  assign ped_walk    = (phase_q == B_GREEN);
  assign ped_pending = ped_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: directed scenarios with literal
// expectations plus randomized stimulus, all checked every cycle against a
// phase-table reference model.
module tb_traffic_intersection_ctrl;

  localparam int TPS  = 4;
  localparam int GA   = 15;
  localparam int GB   = 10;
  localparam int Y    = 3;
  localparam int R    = 1;
  localparam int MING = 5;
  localparam int TW   = 7;

  logic          clk = 1'b0;
  logic          rst, en, night, ped_req;
  logic [2:0]    light_a, light_b, phase;
  logic [TW-1:0] remain_a, remain_b;
  logic          ped_walk, ped_pending, sec_tick;

  traffic_intersection_ctrl #(
    .pTICKS_PER_SEC(TPS), .pT_GREEN_A(GA), .pT_GREEN_B(GB), .pT_YELLOW(Y),
    .pT_ALL_RED(R), .pT_MIN_GREEN(MING), .pTIME_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .night(night), .ped_req(ped_req),
    .light_a(light_a), .light_b(light_b), .remain_a(remain_a), .remain_b(remain_b),
    .ped_walk(ped_walk), .ped_pending(ped_pending), .sec_tick(sec_tick), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: ring order is index order 0..5, 6 is night
  int         dur[6]        = '{GA, Y, R, GB, Y, R};
  logic [2:0] lamp_a_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] lamp_b_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int m_phase = 0;
  int m_rem   = GA;
  int m_cnt   = 0;
  bit m_pend  = 1'b0;
  bit m_flash = 1'b0;

  function automatic logic [2:0] lamp_of(int ph, bit dir_b, bit fl);
    if (ph == 6) return {1'b0, fl, 1'b0};
    return dir_b ? lamp_b_tab[ph] : lamp_a_tab[ph];
  endfunction

  // Seconds until this direction's lamp differs, walking the ring forward
  function automatic int remain_of(int ph, int r, bit dir_b);
    int t;
    int p;
    if (ph == 6) return 0;
    t = r;
    p = (ph + 1) % 6;
    while (lamp_of(p, dir_b, 1'b0) == lamp_of(ph, dir_b, 1'b0)) begin
      t = t + dur[p];
      p = (p + 1) % 6;
    end
    return t;
  endfunction

  always @(posedge clk) begin : model
    bit tick;
    int old;
    tick = en && (m_cnt == TPS - 1);
    if (rst) begin
      m_phase = 0; m_rem = GA; m_cnt = 0; m_pend = 1'b0; m_flash = 1'b0;
    end else begin
      old = m_phase;
      if (en) m_cnt = (m_cnt + 1) % TPS;
      if (tick) begin
        if (m_phase == 6) begin
          if (!night) begin m_phase = 5; m_rem = R; m_flash = 1'b0; end
          else m_flash = !m_flash;
        end else if (m_phase == 0 && m_pend && m_rem > MING) begin
          m_rem = MING;
        end else if (m_rem > 1) begin
          m_rem = m_rem - 1;
        end else if ((m_phase == 2 || m_phase == 5) && night) begin
          m_phase = 6;
        end else begin
          m_phase = (m_phase + 1) % 6;
          m_rem   = dur[m_phase];
        end
      end
      if (m_phase == 3 && old != 3) m_pend = 1'b0;
      else if (ped_req) m_pend = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("model_light_a",     int'(light_a),     int'(lamp_of(m_phase, 1'b0, m_flash)));
    chk("model_light_b",     int'(light_b),     int'(lamp_of(m_phase, 1'b1, m_flash)));
    chk("model_remain_a",    int'(remain_a),    remain_of(m_phase, m_rem, 1'b0));
    chk("model_remain_b",    int'(remain_b),    remain_of(m_phase, m_rem, 1'b1));
    chk("model_ped_walk",    int'(ped_walk),    int'(m_phase == 3));
    chk("model_ped_pending", int'(ped_pending), int'(m_pend));
    chk("model_sec_tick",    int'(sec_tick),    int'(en && (m_cnt == TPS - 1)));
    chk("model_phase",       int'(phase),       m_phase);
  endtask

  // One clock: compare mid-cycle, then land just after the next rising edge
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int ph, input int limit, input string name);
    int k;
    k = 0;
    while (int'(phase) != ph && k < limit) begin
      cyc();
      k++;
    end
    chk(name, int'(phase), ph);
  endtask

  initial begin
    int walk;
    int exp_ph;
    rst = 1'b1; en = 1'b0; night = 1'b0; ped_req = 1'b0;
    cyc(); cyc();
    rst = 1'b0; en = 1'b1;
    chk("rst_remain_a", int'(remain_a), 15);
    chk("rst_remain_b", int'(remain_b), 19);
    chk("rst_light_a", int'(light_a), 1);
    chk("rst_light_b", int'(light_b), 4);
    chk("rst_phase", int'(phase), 0);
    chk("rst_ped_pending", int'(ped_pending), 0);

    // Full undisturbed ring
    walk = 0;
    for (int n = 1; n <= 132; n++) begin
      cyc();
      if (ped_walk) walk++;
      exp_ph = (n < 60) ? 0 : (n < 72) ? 1 : (n < 76) ? 2 : (n < 116) ? 3 : (n < 128) ? 4 : (n < 132) ? 5 : 0;
      chk("ring_phase", int'(phase), exp_ph);
      if (n == 4) begin
        chk("tick1_remain_a", int'(remain_a), 14);
        chk("tick1_remain_b", int'(remain_b), 18);
      end
      if (n == 72) begin
        chk("allred1_remain_a", int'(remain_a), 15);
        chk("allred1_remain_b", int'(remain_b), 1);
      end
    end
    chk("ring_walk_cycles", walk, 40);
    chk("ring_back_remain_a", int'(remain_a), 15);

    // Request shortens A green from 12 s to 5 s
    repeat (12) cyc();
    chk("sec3_remain_a", int'(remain_a), 12);
    ped_req = 1'b1; cyc(); ped_req = 1'b0;
    chk("ped_latched", int'(ped_pending), 1);
    repeat (3) cyc();
    chk("shorten_rem", int'(remain_a), 5);
    repeat (19) cyc();
    chk("short_green_end", int'(phase), 0);
    cyc();
    chk("short_yellow_start", int'(phase), 1);
    repeat (15) cyc();
    chk("pend_before_bgreen", int'(ped_pending), 1);
    cyc();
    chk("bgreen_entry", int'(phase), 3);
    chk("pend_cleared", int'(ped_pending), 0);
    walk = 0;
    repeat (40) begin
      if (ped_walk) walk++;
      cyc();
    end
    chk("walk_cycles", walk, 40);
    chk("byellow_after_walk", int'(phase), 4);

    // Late request: no shortening below the remaining time
    repeat (16) cyc();
    chk("agreen2_phase", int'(phase), 0);
    repeat (44) cyc();
    chk("late_rem4", int'(remain_a), 4);
    ped_req = 1'b1; cyc(); ped_req = 1'b0;
    repeat (3) cyc();
    chk("late_rem3", int'(remain_a), 3);
    repeat (4) cyc();
    chk("late_rem2", int'(remain_a), 2);
    repeat (4) cyc();
    chk("late_rem1", int'(remain_a), 1);
    repeat (4) cyc();
    chk("late_yellow", int'(phase), 1);
    repeat (15) cyc();
    ped_req = 1'b1; cyc(); ped_req = 1'b0;
    chk("coincide_phase", int'(phase), 3);
    chk("coincide_pend", int'(ped_pending), 0);

    // Night mode entry, flashing, exit
    night = 1'b1;
    repeat (55) cyc();
    chk("pre_night_phase", int'(phase), 5);
    cyc();
    chk("night_phase", int'(phase), 6);
    chk("night_light_a0", int'(light_a), 0);
    chk("night_light_b0", int'(light_b), 0);
    chk("night_remain_a", int'(remain_a), 0);
    chk("night_remain_b", int'(remain_b), 0);
    repeat (4) cyc();
    chk("night_light_a1", int'(light_a), 2);
    chk("night_light_b1", int'(light_b), 2);
    ped_req = 1'b1; cyc(); ped_req = 1'b0;
    repeat (3) cyc();
    chk("night_light_a2", int'(light_a), 0);
    chk("night_pend_held", int'(ped_pending), 1);
    repeat (4) cyc();
    chk("night_light_a3", int'(light_a), 2);
    night = 1'b0;
    repeat (4) cyc();
    chk("exit_phase", int'(phase), 5);
    chk("exit_light_a", int'(light_a), 4);
    chk("exit_light_b", int'(light_b), 4);
    chk("exit_remain_a", int'(remain_a), 1);
    chk("exit_remain_b", int'(remain_b), 20);
    repeat (4) cyc();
    chk("exit_agreen", int'(phase), 0);
    chk("exit_agreen_rem", int'(remain_a), 15);

    // Freeze with en=0 in A yellow
    wait_phase(1, 100, "reach_a_yellow");
    repeat (4) cyc();
    chk("freeze_start_rem", int'(remain_a), 2);
    en = 1'b0;
    repeat (50) begin
      cyc();
      chk("freeze_remain_a", int'(remain_a), 2);
      chk("freeze_remain_b", int'(remain_b), 3);
      chk("freeze_light_a", int'(light_a), 2);
      chk("freeze_phase", int'(phase), 1);
      chk("freeze_sec_tick", int'(sec_tick), 0);
    end
    en = 1'b1;

    // Synchronous reset in B green
    wait_phase(3, 200, "reach_b_green");
    repeat (5) cyc();
    rst = 1'b1; cyc();
    chk("mid_rst_phase", int'(phase), 0);
    chk("mid_rst_remain_a", int'(remain_a), 15);
    chk("mid_rst_remain_b", int'(remain_b), 19);
    chk("mid_rst_light_a", int'(light_a), 1);
    chk("mid_rst_light_b", int'(light_b), 4);
    chk("mid_rst_pend", int'(ped_pending), 0);
    chk("mid_rst_tick", int'(sec_tick), 0);
    rst = 1'b0;

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom % 10) != 0;
      ped_req = ($urandom % 50) == 0;
      if (($urandom % 400) == 0) night = !night;
      rst     = ($urandom % 1500) == 0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
